// File: rtl/mul32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul32_seq_ctrl
//
// Purpose:
//   Multi-cycle RV32M multiply unit (MUL, MULH, MULHSU, MULHU) for the
//   execute stage. A single 16x16 unsigned multiplier (mult16u) is reused
//   over four partial-product cycles. Signed operations multiply magnitudes
//   and apply a final conditional 64-bit two's-complement negate.
//   A zero operand can optionally short-circuit the whole sequence.
//
// Ports:
//   clk        in   1   core clock, all state updates on the rising edge
//   rst_n      in   1   synchronous reset, active-low
//   flush      in   1   kill the in-flight operation and drop any result
//   in_valid   in   1   operation request valid
//   in_ready   out  1   request can be accepted (high only in IDLE)
//   op         in   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
//   operand_a  in   32  rs1 value
//   operand_b  in   32  rs2 value
//   out_valid  out  1   result valid (high only in DONE)
//   out_ready  in   1   consumer accepts the result
//   result     out  32  MUL: product[31:0], others: product[63:32];
//                       forced to 0 whenever out_valid is low
//
// Parameters:
//   ZERO_BYPASS  when non-zero, a zero operand completes in one cycle
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// mult16u
//
// Purpose:
//   Combinational 16x16 unsigned multiplier built as a sum of shifted
//   partial-product rows.
//
// Ports:
//   a  in   16  multiplicand
//   b  in   16  multiplier
//   p  out  32  full unsigned product a*b
// ---------------------------------------------------------------------------
module mult16u (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] row [16];

  // One row per multiplier bit: a shifted into position when that bit is set.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_row
      assign row[gi] = b[gi] ? ({16'd0, a} << gi) : 32'd0;
    end
  endgenerate

  always_comb begin
    p = 32'd0;
    for (int i = 0; i < 16; i++) begin
      p = p + row[i];
    end
  end

endmodule

module mul32_seq_ctrl #(
  parameter int unsigned ZERO_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [63:0] acc_reg, acc_next;
  logic [31:0] a_mag_reg, a_mag_next;
  logic [31:0] b_mag_reg, b_mag_next;
  logic [1:0]  op_reg, op_next;
  logic        neg_reg, neg_next;

  // -------------------------------------------------------------------------
  // Operand conditioning at accept: signedness per op, magnitudes, sign
  // -------------------------------------------------------------------------
  logic        a_is_signed, b_is_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        any_zero;

  always_comb begin
    a_is_signed = (op == OP_MULH) || (op == OP_MULHSU);
    b_is_signed = (op == OP_MULH);
    a_neg       = a_is_signed & operand_a[31];
    b_neg       = b_is_signed & operand_b[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    a_mag       = a_neg ? (~operand_a + 32'd1) : operand_a;
    b_mag       = b_neg ? (~operand_b + 32'd1) : operand_b;
    any_zero    = (operand_a == 32'd0) || (operand_b == 32'd0);
  end

  // -------------------------------------------------------------------------
  // Shared 16x16 multiplier and partial-product alignment
  //   cnt 0: a_lo*b_lo << 0
  //   cnt 1: a_lo*b_hi << 16
  //   cnt 2: a_hi*b_lo << 16
  //   cnt 3: a_hi*b_hi << 32
  // cnt[1] selects the a half and cnt[0] selects the b half.
  // -------------------------------------------------------------------------
  logic [15:0] mult_a, mult_b;
  logic [31:0] mult_p;
  logic [63:0] pp_aligned;

  always_comb begin
    mult_a = cnt_reg[1] ? a_mag_reg[31:16] : a_mag_reg[15:0];
    mult_b = cnt_reg[0] ? b_mag_reg[31:16] : b_mag_reg[15:0];
  end

  mult16u u_mult16u (
    .a (mult_a),
    .b (mult_b),
    .p (mult_p)
  );

  always_comb begin
    case (cnt_reg)
      2'd0:    pp_aligned = {32'd0, mult_p};
      2'd1,
      2'd2:    pp_aligned = {16'd0, mult_p, 16'd0};
      default: pp_aligned = {mult_p, 32'd0};
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    a_mag_next = a_mag_reg;
    b_mag_next = b_mag_reg;
    op_next    = op_reg;
    neg_next   = neg_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          op_next    = op;
          a_mag_next = a_mag;
          b_mag_next = b_mag;
          neg_next   = a_neg ^ b_neg;
          acc_next   = 64'd0;
          cnt_next   = 2'd0;
          if ((ZERO_BYPASS != 0) && any_zero) begin
            state_next = S_DONE;
          end else begin
            state_next = S_MUL;
          end
        end
      end

      S_MUL: begin
        // Sum of the four aligned partials of two 32-bit magnitudes fits in
        // 64 bits, so the truncating add never loses information.
        acc_next = acc_reg + pp_aligned;
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == 2'd3) begin
          state_next = S_SIGN;
        end
      end

      S_SIGN: begin
        acc_next   = neg_reg ? (~acc_reg + 64'd1) : acc_reg;
        state_next = S_DONE;
      end

      S_DONE: begin
        out_valid = 1'b1;
        // Return to IDLE only; a new request is taken on a later edge.
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Flush overrides every transition, including the result handshake.
    if (flush) begin
      state_next = S_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Result selection, gated by out_valid
  // -------------------------------------------------------------------------
  always_comb begin
    result = 32'd0;
    if (out_valid) begin
      result = (op_reg == OP_MUL) ? acc_reg[31:0] : acc_reg[63:32];
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 2'd0;
      acc_reg   <= 64'd0;
      a_mag_reg <= 32'd0;
      b_mag_reg <= 32'd0;
      op_reg    <= OP_MUL;
      neg_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      a_mag_reg <= a_mag_next;
      b_mag_reg <= b_mag_next;
      op_reg    <= op_next;
      neg_reg   <= neg_next;
    end
  end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul32_seq_ctrl
//
// Purpose:
//   Self-checking bench for mul32_seq_ctrl. Two instances are used: dut with
//   ZERO_BYPASS=1 (main target) and dut_nb with ZERO_BYPASS=0. Inputs are
//   driven and outputs sampled on the falling clock edge. Expected results
//   come from plain 64-bit arithmetic on sign/zero-extended operands.
// ---------------------------------------------------------------------------
module tb_mul32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;

  logic        in_valid, out_ready, in_ready, out_valid;
  logic [31:0] result;
  logic        in_valid_nb, out_ready_nb, in_ready_nb, out_valid_nb;
  logic [31:0] result_nb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mul32_seq_ctrl #(.ZERO_BYPASS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  mul32_seq_ctrl #(.ZERO_BYPASS(0)) dut_nb (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .in_valid  (in_valid_nb),
    .in_ready  (in_ready_nb),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid_nb),
    .out_ready (out_ready_nb),
    .result    (result_nb)
  );

  // Reference: full 64-bit product of the operands as RV32M interprets them.
  function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == 2'd1 || o == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Issue one request to the selected instance and wait (bounded) for
  // out_valid with out_ready low. lat counts falling edges after the accept
  // edge; -1 means out_valid never arrived. Leaves the instance in DONE.
  task automatic run_op(input bit sel, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b;
    out_ready = 1'b0; out_ready_nb = 1'b0;
    if (sel) in_valid_nb = 1'b1; else in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_valid_nb = 1'b0;
    // Operands must have been captured at accept.
    op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
    lat = -1; res = 32'hDEAD_BEEF;
    for (int k = 1; k <= 20; k++) begin
      if (sel ? out_valid_nb : out_valid) begin
        lat = k;
        res = sel ? result_nb : result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input bit sel);
    if (sel) out_ready_nb = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; out_ready_nb = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid_nb = 1'b0; out_ready_nb = 1'b0;
    op = 2'd0; operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (result !== 32'd0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
    n_checks++; if (in_ready_nb !== 1'b1) $display("FAIL reset_in_ready_nb: got %b want 1", in_ready_nb); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [7] = '{2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
    logic [31:0] t_a  [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'h0001_2345, 32'h8000_0001};
    logic [31:0] t_b  [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0007,
                              32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0002};
    logic [31:0] t_r  [7] = '{32'hFFFF_FFFE, 32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'h2345_0000, 32'h0000_0001};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, t_op[i], t_a[i], t_b[i], res, lat);
      $display("directed op=%0d a=%h b=%h result=%h lat=%0d", t_op[i], t_a[i], t_b[i], res, lat);
      n_checks++; if (res !== t_r[i]) $display("FAIL directed_result[%0d]: got %h want %h", i, res, t_r[i]); else n_pass++;
      n_checks++; if (lat != 6) $display("FAIL directed_latency[%0d]: got %0d want 6", i, lat); else n_pass++;
      finish_op(1'b0);
      // out_valid for exactly one cycle and in_ready back right after handshake
      n_checks++; if (out_valid !== 1'b0) $display("FAIL directed_valid_drop[%0d]: got %b want 0", i, out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
    end
  endtask

  task automatic test_zero_bypass();
    logic [31:0] res;
    int lat;
    run_op(1'b0, 2'd0, 32'h0001_2345, 32'd0, res, lat);
    $display("bypass=1 op=0 a=00012345 b=0 result=%h lat=%0d", res, lat);
    n_checks++; if (lat != 1) $display("FAIL zb_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (res !== 32'd0) $display("FAIL zb_result: got %h want 0", res); else n_pass++;
    finish_op(1'b0);
    run_op(1'b1, 2'd0, 32'h0001_2345, 32'd0, res, lat);
    $display("bypass=0 op=0 a=00012345 b=0 result=%h lat=%0d", res, lat);
    n_checks++; if (lat != 6) $display("FAIL nozb_latency: got %0d want 6", lat); else n_pass++;
    n_checks++; if (res !== 32'd0) $display("FAIL nozb_result: got %h want 0", res); else n_pass++;
    finish_op(1'b1);
    n_checks++; if (in_ready_nb !== 1'b1) $display("FAIL nozb_in_ready: got %b want 1", in_ready_nb); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [1:0]  t_op [2] = '{2'd3, 2'd0};
    logic [31:0] t_r  [2] = '{32'h0000_0000, 32'hFFFE_0001};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, t_op[i], 32'h0000_FFFF, 32'h0000_FFFF, res, lat);
      $display("backpressure op=%0d a=0000ffff b=0000ffff result=%h lat=%0d", t_op[i], res, lat);
      n_checks++; if (res !== t_r[i]) $display("FAIL bp_result[%0d]: got %h want %h", i, res, t_r[i]); else n_pass++;
      // A competing request during DONE must be ignored.
      op = 2'd0; operand_a = 32'h1234_5678; operand_b = 32'h0000_0003; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid); else n_pass++;
        n_checks++; if (result !== t_r[i]) $display("FAIL bp_hold_result[%0d]: got %h want %h", c, result, t_r[i]); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", c, in_ready); else n_pass++;
      end
      in_valid = 1'b0;
      finish_op(1'b0);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_after_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, a, b;
    int lat, seen;
    // flush in IDLE blocks the accept
    @(negedge clk);
    op = 2'd3; operand_a = 32'h0000_0005; operand_b = 32'h0000_0006;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_idle_block: in_ready got %b want 1", in_ready); else n_pass++;
    // flush at T+3
    op = 2'd3; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_mid_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_mid_out_valid: got %b want 0", out_valid); else n_pass++;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0) $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); else n_pass++;
    a = 32'hC000_0003; b = 32'h7000_0009;
    run_op(1'b0, 2'd1, a, b, res, lat);
    $display("after_flush op=1 a=%h b=%h result=%h lat=%0d", a, b, res, lat);
    n_checks++; if (res !== ref_mul(2'd1, a, b)) $display("FAIL flush_next_result: got %h want %h", res, ref_mul(2'd1, a, b)); else n_pass++;
    // flush while a result is pending in DONE drops it
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_done_drop: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_done_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, a, b;
    int lat, seen;
    @(negedge clk);
    op = 2'd2; operand_a = 32'h8765_4321; operand_b = 32'h1234_5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (result !== 32'd0) $display("FAIL rst_mid_result: got %h want 0", result); else n_pass++;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0) $display("FAIL rst_mid_no_result: got %0d valid cycles want 0", seen); else n_pass++;
    a = 32'hFFFF_FFF0; b = 32'h0000_0010;
    run_op(1'b0, 2'd2, a, b, res, lat);
    $display("after_reset op=2 a=%h b=%h result=%h lat=%0d", a, b, res, lat);
    n_checks++; if (res !== ref_mul(2'd2, a, b)) $display("FAIL rst_next_result: got %h want %h", res, ref_mul(2'd2, a, b)); else n_pass++;
    finish_op(1'b0);
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, exp_r;
    logic [1:0]  o;
    int lat, exp_lat, hold;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: a = 32'd0;
        1: b = 32'd0;
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp_r   = ref_mul(o, a, b);
      exp_lat = (a == 32'd0 || b == 32'd0) ? 1 : 6;
      run_op(1'b0, o, a, b, res, lat);
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      $display("random op=%0d a=%h b=%h result=%h lat=%0d", o, a, b, res, lat);
      n_checks++; if (res !== exp_r) $display("FAIL rand_result[%0d]: got %h want %h", i, res, exp_r); else n_pass++;
      n_checks++; if (lat != exp_lat) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, exp_lat); else n_pass++;
      n_checks++; if (result !== exp_r) $display("FAIL rand_held[%0d]: got %h want %h", i, result, exp_r); else n_pass++;
      finish_op(1'b0);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rand_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int first_v, second_v;
    first_v = -1; second_v = -1; r1 = 32'd0; r2 = 32'd0;
    @(negedge clk);
    op = 2'd0; operand_a = 32'h0000_1234; operand_b = 32'h0000_5678;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first_v < 0) begin
          first_v = k; r1 = result;
          op = 2'd3; operand_a = 32'hDEAD_BEEF; operand_b = 32'hCAFE_F00D;
        end else if (second_v < 0) begin
          second_v = k; r2 = result;
        end
      end
      if (k == 8) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    $display("b2b first=%0d r1=%h second=%0d r2=%h", first_v, r1, second_v, r2);
    n_checks++; if (first_v != 6) $display("FAIL b2b_first_cycle: got %0d want 6", first_v); else n_pass++;
    n_checks++; if (r1 !== ref_mul(2'd0, 32'h0000_1234, 32'h0000_5678)) $display("FAIL b2b_r1: got %h want %h", r1, ref_mul(2'd0, 32'h0000_1234, 32'h0000_5678)); else n_pass++;
    n_checks++; if (second_v != 13) $display("FAIL b2b_second_cycle: got %0d want 13", second_v); else n_pass++;
    n_checks++; if (r2 !== ref_mul(2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D)) $display("FAIL b2b_r2: got %h want %h", r2, ref_mul(2'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D)); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_bypass();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
